// File: rtl/z80_trace_pkg.sv
// Shared type codes and width helpers for the Z80 bus tracer.
// Optional timestamp field enabled by defining Z80_TRACE_TIMESTAMP_EN.
package z80_trace_pkg;

  localparam logic [1:0] TR_MEM_RD = 2'b00;
  localparam logic [1:0] TR_MEM_WR = 2'b01;
  localparam logic [1:0] TR_IO_RD  = 2'b10;
  localparam logic [1:0] TR_IO_WR  = 2'b11;

  localparam int OVF_W = 16;

`ifdef Z80_TRACE_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  // Trace word = {[ts,] type, addr, data}
  function automatic int word_w(input int addr_w, input int data_w, input int ts_w);
    return 2 + addr_w + data_w + (TS_EN ? ts_w : 0);
  endfunction

endpackage

// File: rtl/z80_trace_fifo.sv
// First-word-fall-through FIFO with wrap-bit pointers; a pop frees a slot
// for a push on the same clock even when full.
module z80_trace_fifo #(
  parameter int WIDTH = 26,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign valid   = !empty;
  assign level   = wr_ptr - rd_ptr;
  // Gated so the head reads zero while empty, storage itself is never reset
  assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/z80_bus_tracer.sv
// Passive Z80 bus observer: captures completed mem/IO cycles into a trace FIFO.
// Define Z80_TRACE_TIMESTAMP_EN to prepend a free-running timestamp to each word.
module z80_bus_tracer
  import z80_trace_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int TS_W   = 16
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [ADDR_W-1:0]                     address,
  input  logic [DATA_W-1:0]                     dbus_in,
  input  logic [DATA_W-1:0]                     dbus_out,
  input  logic                                  rd_n,
  input  logic                                  wr_n,
  input  logic                                  mreq_n,
  input  logic                                  iorq_n,
  input  logic                                  trace_en,
  input  logic [3:0]                            type_mask,
  output logic                                  tr_valid,
  input  logic                                  tr_ready,
  output logic [word_w(ADDR_W, DATA_W, TS_W)-1:0] tr_data,
  output logic [$clog2(DEPTH):0]                level,
  output logic [OVF_W-1:0]                      overflow
);

  localparam int W = word_w(ADDR_W, DATA_W, TS_W);

  function automatic logic [OVF_W-1:0] sat_inc(input logic [OVF_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  logic              active;
  logic [1:0]        cyc_type;
  logic              vld_p0;
  logic [1:0]        type_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [DATA_W-1:0] data_p0;
  logic              complete;
  logic              push_req;
  logic              pop;
  logic              fifo_full;
  logic [W-1:0]      word;

  // Exactly one request and exactly one strobe; int-ack (iorq, no strobe) falls out
  assign active   = (mreq_n ^ iorq_n) && (rd_n ^ wr_n);
  assign cyc_type = !iorq_n ? (!wr_n ? TR_IO_WR  : TR_IO_RD)
                            : (!wr_n ? TR_MEM_WR : TR_MEM_RD);

  // ---- stage p0: cycle snapshot, edge-detect flag ----
  always_ff @(posedge clk) begin
    if (reset) vld_p0 <= 1'b0;
    else       vld_p0 <= active;
  end

  always_ff @(posedge clk) begin
    if (active) begin
      type_p0 <= cyc_type;
      addr_p0 <= address;
      data_p0 <= wr_n ? dbus_in : dbus_out;
    end
  end

  assign complete = vld_p0 && !active;
  assign push_req = complete && trace_en && type_mask[type_p0];
  assign pop      = tr_valid && tr_ready;

`ifdef Z80_TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt;

  always_ff @(posedge clk) begin
    if (reset) ts_cnt <= '0;
    else       ts_cnt <= ts_cnt + 1'b1;
  end

  assign word = {ts_cnt, type_p0, addr_p0, data_p0};
`else
  assign word = {type_p0, addr_p0, data_p0};
`endif

  always_ff @(posedge clk) begin
    if (reset)                            overflow <= '0;
    else if (push_req && fifo_full && !pop) overflow <= sat_inc(overflow);
  end

  // ---- stage p1: FIFO storage, head visible one clock after completion ----
  z80_trace_fifo #(
    .WIDTH (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .wdata (word),
    .pop   (pop),
    .rdata (tr_data),
    .valid (tr_valid),
    .full  (fifo_full),
    .level (level)
  );

endmodule
